pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Next-PC sequencer and pipeline stall/flush controller for the 5-stage MIPS core.
- Drives the PC register's next value and enable, the IF/ID enable, and the per-stage flushes.
- Arbitrates PC-update sources in this order: exception, eret, stall, jump, branch, sequential.
- Owns the multiply/divide busy counter and a saturating stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'h0000_4180, exception handler address.
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc_f  in  32  current PC (fetch stage)
- load_use_stall  in  1  data-hazard stall request from the hazard unit
- md_start_e  in  1  mult/div instruction in E this cycle
- md_is_div_e  in  1  1 = div/divu, 0 = mult/multu (qualified by md_start_e)
- md_use_d  in  1  D-stage instruction reads or writes HI/LO or starts a mult/div
- jump_d  in  1  j/jal/jr/jalr resolved in D
- jump_target_d  in  32  jump target
- branch_taken_d  in  1  branch resolved taken in D
- branch_target_d  in  32  branch target
- exc_req_m  in  1  exception raised in M
- eret_m  in  1  eret in M
- epc_m  in  32  EPC value for eret
- pc_next  out  32  next PC value to the PC register
- pc_en  out  1  PC register enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID
- idex_flush  out  1  clear ID/EX (insert bubble)
- exmem_flush  out  1  clear EX/MEM
- md_busy  out  1  mult/div unit busy
- stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Registered state: md_cnt (4 bits), md_state {MD_IDLE, MD_BUSY}, stall_cnt. All other outputs are combinational from inputs and state.
- During reset:
  - pc_en=0, ifid_en=0; ifid_flush=idex_flush=exmem_flush=1.
  - pc_next=32'h0.
  - Next cycle: md_cnt=0, md_state=MD_IDLE, md_busy=0, stall_cnt=0.
- md_busy = (md_state==MD_BUSY).
- md stall = md_use_d & (md_busy | md_start_e).
- stall = load_use_stall | md stall.
- Priority per cycle, highest first:
  1. exc_req_m: pc_next=EXC_VECTOR, pc_en=1, ifid_flush=idex_flush=exmem_flush=1, ifid_en=1. Overrides stall, jump, branch and eret in the same cycle.
  2. eret_m: pc_next=epc_m, pc_en=1, ifid_flush=idex_flush=exmem_flush=1, ifid_en=1.
  3. stall: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, exmem_flush=0. pc_next=pc_f+4; the value is ignored while pc_en=0.
  4. jump_d: pc_next=jump_target_d, pc_en=1, no flush (delay slot executes). jump_d beats branch_taken_d.
  5. branch_taken_d: pc_next=branch_target_d, pc_en=1, no flush.
  6. Otherwise: pc_next=pc_f+32'd4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), pc_en=1, ifid_en=1, all flushes 0.
- A jump or branch during a stall is not taken. The D instruction is held and re-resolves once the stall clears.
- md FSM:
  - MD_IDLE + md_start_e, no exception: load md_cnt = md_is_div_e ? DIV_CYCLES : MULT_CYCLES; go to MD_BUSY.
  - MD_BUSY: md_cnt decrements each cycle. On md_cnt==1, go to MD_IDLE with md_cnt=0. busy lasts exactly N cycles after the start cycle.
  - md_start_e while MD_BUSY: reload the counter (restart). This is only reachable by hazard-unit error; the restart is required behaviour.
  - exc_req_m: md_cnt=0, md_state=MD_IDLE in the next cycle. A start in the same cycle is discarded. eret does not affect the FSM.
- stall_cnt increments on each cycle with stall=1 and exc_req_m=0 and eret_m=0. It saturates at 32'hFFFF_FFFF; no wrap.
- Mid-operation reset: the FSM and counters clear on the next edge regardless of md_cnt.

Test Plan:
- Reset then release, pc_f=0, no requests -> pc_next=4, pc_en=1, all flushes 0, md_busy=0, stall_cnt=0.
- jump_d=1 with jump_target_d=32'h0000_3000 and branch_taken_d=1 with branch_target_d=32'h0000_2000 in the same cycle -> pc_next=32'h3000, no flush.
- md_start_e=1, md_is_div_e=1, then md_use_d=1 next cycle:
  - md_busy=1 for exactly 10 cycles.
  - pc_en=0 and idex_flush=1 in each of those cycles.
  - stall_cnt=10 afterward; normal flow resumes on cycle 11.
- load_use_stall=1 and exc_req_m=1 together -> pc_next=32'h4180, pc_en=1, all three flushes 1, stall_cnt unchanged.
- Mult in progress (md_cnt=3), exc_req_m=1 -> md_busy=0 next cycle. eret_m=1 with epc_m=32'h0000_0040 -> pc_next=32'h40 with flushes.
- pc_f=32'hFFFF_FFFC, no requests -> pc_next=0. stall_cnt preset at saturation by a long stall run -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pc_ctrl_if.sv
// Bundle of fetch/decode/execute/memory-stage signals exchanged with pc_ctrl.
interface pc_ctrl_if;
    // Requests and context from the pipeline
    logic [31:0] pc_f;
    logic        load_use_stall;
    logic        md_start_e;
    logic        md_is_div_e;
    logic        md_use_d;
    logic        jump_d;
    logic [31:0] jump_target_d;
    logic        branch_taken_d;
    logic [31:0] branch_target_d;
    logic        exc_req_m;
    logic        eret_m;
    logic [31:0] epc_m;

    // Control back to the pipeline
    logic [31:0] pc_next;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        md_busy;
    logic [31:0] stall_cnt;

    // Pipeline side: drives requests, consumes controls
    modport master (
        output pc_f, load_use_stall, md_start_e, md_is_div_e, md_use_d,
               jump_d, jump_target_d, branch_taken_d, branch_target_d,
               exc_req_m, eret_m, epc_m,
        input  pc_next, pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush,
               md_busy, stall_cnt
    );

    // Controller side
    modport slave (
        input  pc_f, load_use_stall, md_start_e, md_is_div_e, md_use_d,
               jump_d, jump_target_d, branch_taken_d, branch_target_d,
               exc_req_m, eret_m, epc_m,
        output pc_next, pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush,
               md_busy, stall_cnt
    );
endinterface

// File: rtl/pc_ctrl.sv
// Next-PC sequencer, stall/flush control, mult/div busy tracking and
// saturating stall-cycle counter for the 5-stage core.
module pc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic         clk,
    input logic         reset,
    pc_ctrl_if.slave    bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned PC_W  = 32;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e          md_state_q, md_state_d;
    logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic [PC_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic               md_busy_c;
    logic               md_stall_c;
    logic               stall_c;
    logic [PC_W-1:0]    pc_seq_c;

    logic [PC_W-1:0]    pc_next_c;
    logic               pc_en_c;
    logic               ifid_en_c;
    logic               ifid_flush_c;
    logic               idex_flush_c;
    logic               exmem_flush_c;

    // Hazard terms shared by the PC mux and the stall counter
    always_comb begin
        md_busy_c  = (md_state_q == MD_BUSY);
        md_stall_c = bus.md_use_d & (md_busy_c | bus.md_start_e);
        stall_c    = bus.load_use_stall | md_stall_c;
        pc_seq_c   = bus.pc_f + PC_W'(4);
    end

    // PC source arbitration: exception > eret > stall > jump > branch > sequential
    always_comb begin
        pc_next_c     = pc_seq_c;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;

        if (reset) begin
            pc_next_c     = '0;
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
        end else if (bus.exc_req_m) begin
            pc_next_c     = EXC_VECTOR;
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
        end else if (bus.eret_m) begin
            pc_next_c     = bus.epc_m;
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
        end else if (stall_c) begin
            // Hold F and D, bubble into E; a pending jump/branch re-resolves later
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_flush_c  = 1'b1;
        end else if (bus.jump_d) begin
            pc_next_c     = bus.jump_target_d;
        end else if (bus.branch_taken_d) begin
            pc_next_c     = bus.branch_target_d;
        end
    end

    // Mult/div busy FSM and saturating stall counter next-state
    always_comb begin
        md_state_d  = md_state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (bus.exc_req_m) begin
            // Exception kills the unit; a start in the same cycle is dropped
            md_state_d = MD_IDLE;
            md_cnt_d   = '0;
        end else if (bus.md_start_e) begin
            // Start or restart: reload the full latency
            md_state_d = MD_BUSY;
            md_cnt_d   = bus.md_is_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_state_q == MD_BUSY) begin
            if (md_cnt_q == CNT_W'(1)) begin
                md_state_d = MD_IDLE;
                md_cnt_d   = '0;
            end else begin
                md_cnt_d   = md_cnt_q - CNT_W'(1);
            end
        end

        if (stall_c && !bus.exc_req_m && !bus.eret_m && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PC_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            md_state_q  <= MD_IDLE;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_state_q  <= md_state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Drive the interface
    always_comb begin
        bus.pc_next     = pc_next_c;
        bus.pc_en       = pc_en_c;
        bus.ifid_en     = ifid_en_c;
        bus.ifid_flush  = ifid_flush_c;
        bus.idex_flush  = idex_flush_c;
        bus.exmem_flush = exmem_flush_c;
        bus.md_busy     = md_busy_c;
        bus.stall_cnt   = stall_cnt_q;
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a cycle model pushes expected outputs to a
// scoreboard queue, which is popped and compared once the DUT settles.
module tb_pc_ctrl;

    typedef struct {
        logic [31:0] pc_next;
        logic        pc_en;
        logic        ifid_en;
        logic        ifid_flush;
        logic        idex_flush;
        logic        exmem_flush;
        logic        md_busy;
        logic [31:0] stall_cnt;
    } exp_t;

    logic clk;
    logic reset;
    pc_ctrl_if bus ();

    pc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        sb[$];

    // Reference model state
    int unsigned m_cnt    = 0;
    bit          m_busy   = 1'b0;
    logic [31:0] m_sc     = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   stall;
        stall = bus.load_use_stall | (bus.md_use_d & (m_busy | bus.md_start_e));
        e.pc_next = bus.pc_f + 32'd4;
        e.pc_en = 1; e.ifid_en = 1;
        e.ifid_flush = 0; e.idex_flush = 0; e.exmem_flush = 0;
        e.md_busy = m_busy;
        e.stall_cnt = m_sc;
        if (reset) begin
            e.pc_next = 32'h0; e.pc_en = 0; e.ifid_en = 0;
            e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
        end else if (bus.exc_req_m) begin
            e.pc_next = 32'h0000_4180;
            e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
        end else if (bus.eret_m) begin
            e.pc_next = bus.epc_m;
            e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
        end else if (stall) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_flush = 1;
        end else if (bus.jump_d) begin
            e.pc_next = bus.jump_target_d;
        end else if (bus.branch_taken_d) begin
            e.pc_next = bus.branch_target_d;
        end
        return e;
    endfunction

    // Push expectation, then pop and compare against the settled DUT outputs
    task automatic settle(input bit do_chk);
        exp_t e;
        #1;
        sb.push_back(model_out());
        e = sb.pop_front();
        if (do_chk) begin
            chk("pc_next",     bus.pc_next,           e.pc_next);
            chk("pc_en",       32'(bus.pc_en),        32'(e.pc_en));
            chk("ifid_en",     32'(bus.ifid_en),      32'(e.ifid_en));
            chk("ifid_flush",  32'(bus.ifid_flush),   32'(e.ifid_flush));
            chk("idex_flush",  32'(bus.idex_flush),   32'(e.idex_flush));
            chk("exmem_flush", 32'(bus.exmem_flush),  32'(e.exmem_flush));
            chk("md_busy",     32'(bus.md_busy),      32'(e.md_busy));
            chk("stall_cnt",   bus.stall_cnt,         e.stall_cnt);
        end
    endtask

    // Advance the model across the coming clock edge
    task automatic advance();
        bit stall;
        stall = bus.load_use_stall | (bus.md_use_d & (m_busy | bus.md_start_e));
        if (reset) begin
            m_cnt = 0; m_busy = 0; m_sc = 32'h0;
        end else begin
            if (stall && !bus.exc_req_m && !bus.eret_m && m_sc != 32'hFFFF_FFFF)
                m_sc = m_sc + 32'd1;
            if (bus.exc_req_m) begin
                m_cnt = 0; m_busy = 0;
            end else if (bus.md_start_e) begin
                m_cnt = bus.md_is_div_e ? 10 : 5; m_busy = 1;
            end else if (m_busy) begin
                if (m_cnt == 1) begin m_cnt = 0; m_busy = 0; end
                else m_cnt = m_cnt - 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic clear_inputs();
        bus.pc_f = 32'h0000_0100;
        bus.load_use_stall = 0; bus.md_start_e = 0; bus.md_is_div_e = 0;
        bus.md_use_d = 0; bus.jump_d = 0; bus.jump_target_d = 32'h0;
        bus.branch_taken_d = 0; bus.branch_target_d = 32'h0;
        bus.exc_req_m = 0; bus.eret_m = 0; bus.epc_m = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1;

        // Reset: first edge establishes state, second cycle is checked
        @(negedge clk); settle(0); advance();
        @(negedge clk); settle(1);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst_pc_next", bus.pc_next, 32'h0);
        advance();

        // Release, sequential fetch from 0
        @(negedge clk); reset = 0; bus.pc_f = 32'h0; settle(1);
        chk("seq_pc_next", bus.pc_next, 32'h4);
        advance();

        // Jump beats branch in the same cycle
        @(negedge clk); clear_inputs();
        bus.jump_d = 1; bus.jump_target_d = 32'h0000_3000;
        bus.branch_taken_d = 1; bus.branch_target_d = 32'h0000_2000;
        settle(1);
        chk("jmp_pc_next", bus.pc_next, 32'h0000_3000);
        advance();

        // Branch alone
        @(negedge clk); clear_inputs();
        bus.branch_taken_d = 1; bus.branch_target_d = 32'h0000_2000;
        settle(1); advance();

        // Divide start, then dependent instruction stalls for 10 cycles
        @(negedge clk); clear_inputs(); bus.md_start_e = 1; bus.md_is_div_e = 1;
        settle(1); advance();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); clear_inputs(); bus.md_use_d = 1;
            bus.jump_d = 1; bus.jump_target_d = 32'h0000_5000;
            settle(1);
            chk("div_busy", 32'(bus.md_busy), 32'd1);
            chk("div_pc_en", 32'(bus.pc_en), 32'd0);
            advance();
        end
        @(negedge clk); clear_inputs(); bus.md_use_d = 1;
        bus.jump_d = 1; bus.jump_target_d = 32'h0000_5000;
        settle(1);
        chk("div_done_cnt", bus.stall_cnt, 32'd10);
        chk("div_resume_pc", bus.pc_next, 32'h0000_5000);
        advance();

        // Exception overrides a load-use stall; counter untouched
        @(negedge clk); clear_inputs(); bus.load_use_stall = 1; bus.exc_req_m = 1;
        bus.eret_m = 1; bus.epc_m = 32'h0000_0040;
        settle(1);
        chk("exc_pc_next", bus.pc_next, 32'h0000_4180);
        advance();
        @(negedge clk); clear_inputs(); settle(1);
        chk("exc_stall_cnt", bus.stall_cnt, 32'd10);
        advance();

        // Mult interrupted by an exception at md_cnt == 3
        @(negedge clk); clear_inputs(); bus.md_start_e = 1; settle(1); advance();
        @(negedge clk); clear_inputs(); settle(1); advance();
        @(negedge clk); clear_inputs(); settle(1); advance();
        @(negedge clk); clear_inputs(); bus.exc_req_m = 1; bus.md_start_e = 1;
        settle(1); advance();
        @(negedge clk); clear_inputs(); settle(1);
        chk("exc_md_busy", 32'(bus.md_busy), 32'd0);
        advance();

        // Eret redirect
        @(negedge clk); clear_inputs(); bus.eret_m = 1; bus.epc_m = 32'h0000_0040;
        bus.load_use_stall = 1;
        settle(1);
        chk("eret_pc_next", bus.pc_next, 32'h0000_0040);
        advance();

        // Sequential wrap
        @(negedge clk); clear_inputs(); bus.pc_f = 32'hFFFF_FFFC; settle(1);
        chk("wrap_pc_next", bus.pc_next, 32'h0);
        advance();

        // Restart: mult then div one cycle later reloads the full 10 cycles
        @(negedge clk); clear_inputs(); bus.md_start_e = 1; settle(1); advance();
        @(negedge clk); clear_inputs(); bus.md_start_e = 1; bus.md_is_div_e = 1;
        settle(1); advance();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); clear_inputs(); settle(1); advance();
        end

        // Mid-operation reset
        @(negedge clk); clear_inputs(); bus.md_start_e = 1; bus.md_is_div_e = 1;
        settle(1); advance();
        @(negedge clk); clear_inputs(); bus.load_use_stall = 1; settle(1); advance();
        @(negedge clk); clear_inputs(); reset = 1; settle(1); advance();
        @(negedge clk); reset = 0; settle(1);
        chk("midrst_busy", 32'(bus.md_busy), 32'd0);
        chk("midrst_cnt", bus.stall_cnt, 32'd0);
        advance();

        // Saturation: preset the counter near its ceiling
        @(negedge clk); clear_inputs(); bus.load_use_stall = 1;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        chk("sat_out", bus.stall_cnt, 32'hFFFF_FFFE);
        chk("sat_inc", dut.stall_cnt_d, 32'hFFFF_FFFF);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        chk("sat_hold", dut.stall_cnt_d, 32'hFFFF_FFFF);
        release dut.stall_cnt_q;
        reset = 1;
        m_cnt = 0; m_busy = 0; m_sc = 32'h0;
        @(posedge clk);
        @(negedge clk); reset = 0; clear_inputs(); settle(1); advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
